sap_u_controller: RTL

SAP_U_CONTROLLER -- requirements
Module: sap_u_controller

---
 rtl/sap_u_controller.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/sap_u_controller.sv
// SAP-1 style microcoded controller: five T-state ring plus HALT.
// Optional build macro SAP_U_JUMP_EN adds JMP (0110) and JC (0111).
module sap_u_controller (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  opcode,
  input  logic        carry_flag,
  output logic [12:0] ctrl,
  output logic [2:0]  tstate,
  output logic        halted
);

  localparam int PC_INC    = 0;
  localparam int PC_EN     = 1;
  localparam int PC_LOAD   = 2;
  localparam int MAR_LOAD  = 3;
  localparam int RAM_EN    = 4;
  localparam int IR_LOAD   = 5;
  localparam int IR_EN     = 6;
  localparam int A_LOAD    = 7;
  localparam int A_EN      = 8;
  localparam int B_LOAD    = 9;
  localparam int ALU_EN    = 10;
  localparam int ALU_SUB   = 11;
  localparam int OUT_LOAD  = 12;

  localparam logic [3:0] OP_NOP = 4'b0000;
  localparam logic [3:0] OP_LDA = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0011;
  localparam logic [3:0] OP_LDI = 4'b0100;
  localparam logic [3:0] OP_JMP = 4'b0110;
  localparam logic [3:0] OP_JC  = 4'b0111;
  localparam logic [3:0] OP_OUT = 4'b1110;
  localparam logic [3:0] OP_HLT = 4'b1111;

  typedef enum logic {
    RUN,
    HALT
  } state_t;

  state_t      state_q;
  state_t      state_d;
  logic [2:0]  t_q;
  logic [2:0]  t_d;
  logic [12:0] word;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= RUN;
      t_q     <= 3'd0;
    end else begin
      state_q <= state_d;
      t_q     <= t_d;
    end
  end

  always_comb begin
    state_d = state_q;
    t_d     = t_q;
    unique case (state_q)
      RUN: begin
        if (t_q == 3'd2 && opcode == OP_HLT) begin
          state_d = HALT;
        end else if (t_q >= 3'd4) begin
          t_d = 3'd0;
        end else begin
          t_d = t_q + 3'd1;
        end
      end
      HALT: begin
        t_d = 3'd2;
      end
      default: begin
        state_d = RUN;
        t_d     = 3'd0;
      end
    endcase
  end

`ifndef SAP_U_JUMP_EN
  logic unused_carry;
  assign unused_carry = carry_flag;
`endif

  always_comb begin
    word = '0;
    unique case (1'b1)
      (t_q == 3'd0): begin
        word[PC_EN]    = 1'b1;
        word[MAR_LOAD] = 1'b1;
      end
      (t_q == 3'd1): begin
        word[RAM_EN]  = 1'b1;
        word[IR_LOAD] = 1'b1;
        word[PC_INC]  = 1'b1;
      end
      (t_q == 3'd2): begin
        case (opcode)
          OP_LDA, OP_ADD, OP_SUB: begin
            word[IR_EN]    = 1'b1;
            word[MAR_LOAD] = 1'b1;
          end
          OP_LDI: begin
            word[IR_EN]  = 1'b1;
            word[A_LOAD] = 1'b1;
          end
          OP_OUT: begin
            word[A_EN]     = 1'b1;
            word[OUT_LOAD] = 1'b1;
          end
`ifdef SAP_U_JUMP_EN
          OP_JMP: begin
            word[IR_EN]   = 1'b1;
            word[PC_LOAD] = 1'b1;
          end
          OP_JC: begin
            word[IR_EN]   = carry_flag;
            word[PC_LOAD] = carry_flag;
          end
`endif
          default: word = '0;
        endcase
      end
      (t_q == 3'd3): begin
        case (opcode)
          OP_LDA: begin
            word[RAM_EN] = 1'b1;
            word[A_LOAD] = 1'b1;
          end
          OP_ADD, OP_SUB: begin
            word[RAM_EN]  = 1'b1;
            word[B_LOAD]  = 1'b1;
            word[ALU_SUB] = (opcode == OP_SUB);
          end
          default: word = '0;
        endcase
      end
      (t_q == 3'd4): begin
        if (opcode == OP_ADD || opcode == OP_SUB) begin
          word[ALU_EN]  = 1'b1;
          word[A_LOAD]  = 1'b1;
          word[ALU_SUB] = (opcode == OP_SUB);
        end
      end
      default: word = '0;
    endcase
  end

  // Reset suppresses the word at once so an interrupted instruction
  // never gets to pulse its remaining loads.
  assign ctrl   = (state_q == RUN && !reset) ? word : 13'd0;
  assign tstate = t_q;
  assign halted = (state_q == HALT);

  logic unused_ops;
  assign unused_ops = (OP_NOP == 4'd0) & (OP_JMP != OP_JC);

endmodule
